// File: rtl/beep_pattern_ctrl_if.sv
// Alert request / buzzer control bundle shared by beep_pattern_ctrl and its requesters.
// master drives the requests, slave (the controller) drives the buzzer side.
interface beep_pattern_ctrl_if;
  logic [2:0]  req;
  logic [2:0]  grant;
  logic        busy;
  logic        tone_en;
  logic [15:0] tone_div;
  logic        done;

  modport master (output req, input grant, busy, tone_en, tone_div, done);
  modport slave  (input req, output grant, busy, tone_en, tone_div, done);
endinterface

// File: rtl/beep_pattern_ctrl.sv
// Priority buzzer pattern controller: three alert sources, each with a fixed beep pattern.
// Optional macro BEEP_PREEMPT_EN lets a higher-priority pending alert abort the current pattern.
module beep_pattern_ctrl #(
  parameter int TICK_CYC = 50_000
) (
  input  logic               clk,
  input  logic               rst_n,
  beep_pattern_ctrl_if.slave bus
);

  localparam int               TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_CYC - 1);
  localparam logic [7:0]       GAP_MS   = 8'd200;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t            state_reg;
  logic [2:0]        req_d_reg;
  logic [2:0]        armed_reg;
  logic [2:0]        pending_reg;
  logic [2:0]        grant_reg;
  logic [1:0]        beeps_left_reg;
  logic [TICK_W-1:0] tick_reg;
  logic [7:0]        ms_reg;
  logic              tone_en_reg;
  logic [15:0]       tone_div_reg;
  logic              done_reg;

  logic [2:0]  req_edge;
  logic [2:0]  pick;
  logic [2:0]  take;
  logic [2:0]  pending_next;
  logic [15:0] pick_div;
  logic [1:0]  pick_beeps;
  logic [7:0]  on_ms;
  logic [7:0]  off_ms;
  logic [7:0]  dur_ms;
  logic        last_cyc;
  logic        preempt;

  // armed_reg keeps a level that was already high at reset release from counting as an edge
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bit
      assign req_edge[gi]     = bus.req[gi] & ~req_d_reg[gi] & armed_reg[gi];
      assign pending_next[gi] = (pending_reg[gi] | req_edge[gi]) & ~take[gi];
    end
  endgenerate

  always_comb begin
    pick = 3'b000;
    if (pending_reg[2])      pick = 3'b100;
    else if (pending_reg[1]) pick = 3'b010;
    else if (pending_reg[0]) pick = 3'b001;
  end

  assign take = (state_reg == IDLE) ? pick : 3'b000;

  always_comb begin
    pick_div   = 16'd0;
    pick_beeps = 2'd0;
    case (pick)
      3'b001:  begin pick_div = 16'd8332;  pick_beeps = 2'd0; end
      3'b010:  begin pick_div = 16'd12499; pick_beeps = 2'd1; end
      3'b100:  begin pick_div = 16'd6249;  pick_beeps = 2'd2; end
      default: begin pick_div = 16'd0;     pick_beeps = 2'd0; end
    endcase
  end

  always_comb begin
    on_ms  = 8'd0;
    off_ms = 8'd0;
    case (grant_reg)
      3'b001:  begin on_ms = 8'd100; off_ms = 8'd0;   end
      3'b010:  begin on_ms = 8'd100; off_ms = 8'd100; end
      3'b100:  begin on_ms = 8'd50;  off_ms = 8'd50;  end
      default: begin on_ms = 8'd0;   off_ms = 8'd0;   end
    endcase
  end

  always_comb begin
    dur_ms = 8'd0;
    case (state_reg)
      ON:      dur_ms = on_ms;
      OFF:     dur_ms = off_ms;
      GAP:     dur_ms = GAP_MS;
      default: dur_ms = 8'd0;
    endcase
  end

  assign last_cyc = (tick_reg == TICK_MAX) && (ms_reg == dur_ms - 8'd1);

`ifdef BEEP_PREEMPT_EN
  logic [2:0] higher_mask;
  assign higher_mask = {grant_reg[1] | grant_reg[0], grant_reg[0], 1'b0};
  assign preempt     = (state_reg != IDLE) && (|(pending_reg & higher_mask));
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      req_d_reg      <= 3'b000;
      armed_reg      <= 3'b000;
      pending_reg    <= 3'b000;
      grant_reg      <= 3'b000;
      beeps_left_reg <= 2'd0;
      tick_reg       <= '0;
      ms_reg         <= 8'd0;
      tone_en_reg    <= 1'b0;
      tone_div_reg   <= 16'd0;
      done_reg       <= 1'b0;
    end else begin
      req_d_reg   <= bus.req;
      armed_reg   <= armed_reg | ~bus.req;
      pending_reg <= pending_next;
      done_reg    <= 1'b0;

      if (state_reg != IDLE) begin
        if (tick_reg == TICK_MAX) begin
          tick_reg <= '0;
          ms_reg   <= ms_reg + 8'd1;
        end else begin
          tick_reg <= tick_reg + 1'b1;
        end
      end

      if (preempt) begin
        // abandoned pattern is dropped silently; the winner is arbitrated from IDLE next cycle
        state_reg   <= IDLE;
        grant_reg   <= 3'b000;
        tone_en_reg <= 1'b0;
        tick_reg    <= '0;
        ms_reg      <= 8'd0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (|pending_reg) begin
              state_reg      <= ON;
              grant_reg      <= pick;
              tone_div_reg   <= pick_div;
              beeps_left_reg <= pick_beeps;
              tone_en_reg    <= 1'b1;
              tick_reg       <= '0;
              ms_reg         <= 8'd0;
            end
          end
          ON: begin
            if (last_cyc) begin
              state_reg   <= (beeps_left_reg != 2'd0) ? OFF : GAP;
              tone_en_reg <= 1'b0;
              tick_reg    <= '0;
              ms_reg      <= 8'd0;
            end
          end
          OFF: begin
            if (last_cyc) begin
              state_reg      <= ON;
              beeps_left_reg <= beeps_left_reg - 2'd1;
              tone_en_reg    <= 1'b1;
              tick_reg       <= '0;
              ms_reg         <= 8'd0;
            end
          end
          GAP: begin
            if (last_cyc) begin
              state_reg <= IDLE;
              grant_reg <= 3'b000;
              done_reg  <= 1'b1;
              tick_reg  <= '0;
              ms_reg    <= 8'd0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.grant    = grant_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.tone_en  = tone_en_reg;
  assign bus.tone_div = tone_div_reg;
  assign bus.done     = done_reg;

endmodule
